// File: rtl/tage_pkg.sv
// rtl/tage_pkg.sv - shared sequencer state encoding and default trace geometry
package tage_pkg;

  localparam int DEF_TRAINING_DATA_SIZE = 256;
  localparam int DEF_PC_WIDTH           = 32;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    CAPTURE,
    PREDICT,
    UPDATE,
    DONE
  } state_t;

endpackage

// File: rtl/sat_event_counter.sv
// rtl/sat_event_counter.sv - clearable event counter that sticks at all-ones
module sat_event_counter #(
  parameter int COUNT_WIDTH = 9
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clear_i,
  input  logic                   inc_i,
  output logic [COUNT_WIDTH-1:0] count_o
);

  logic [COUNT_WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != '1)) begin
      count_d = count_q + COUNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/tage_trace_sequencer.sv
// rtl/tage_trace_sequencer.sv - replays the branch trace through the TAGE predict/update ports
module tage_trace_sequencer
  import tage_pkg::*;
#(
  parameter int TRAINING_DATA_SIZE     = DEF_TRAINING_DATA_SIZE,
  parameter int INSTRUCTION_INDEX_SIZE = $clog2(TRAINING_DATA_SIZE),
  parameter int PC_WIDTH               = DEF_PC_WIDTH,
  parameter int COUNT_WIDTH            = INSTRUCTION_INDEX_SIZE + 1
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              start_i,
  input  logic                              abort_i,
  input  logic [COUNT_WIDTH-1:0]            num_instr_i,
  output logic                              trace_rd_en_o,
  output logic [INSTRUCTION_INDEX_SIZE-1:0] trace_addr_o,
  input  logic [PC_WIDTH-1:0]               trace_pc_i,
  input  logic                              trace_taken_i,
  output logic                              pred_req_o,
  output logic [PC_WIDTH-1:0]               pred_pc_o,
  input  logic                              pred_valid_i,
  input  logic                              pred_taken_i,
  output logic                              upd_req_o,
  output logic [PC_WIDTH-1:0]               upd_pc_o,
  output logic                              upd_taken_o,
  output logic                              upd_mispredict_o,
  input  logic                              upd_ack_i,
  output logic                              busy_o,
  output logic                              done_o,
  output logic [COUNT_WIDTH-1:0]            branch_count_o,
  output logic [COUNT_WIDTH-1:0]            mispredict_count_o
);

  state_t                            state_q, state_d;
  logic [INSTRUCTION_INDEX_SIZE-1:0] index_q, index_d;
  logic [COUNT_WIDTH-1:0]            len_q, len_d, len_clamped, branch_next;
  logic [PC_WIDTH-1:0]               pc_q, pc_d;
  logic                              taken_q, taken_d, pred_taken_q, pred_taken_d;
  logic                              cnt_clear, br_inc, mp_inc, active, mispredict;

  assign len_clamped = (num_instr_i > COUNT_WIDTH'(TRAINING_DATA_SIZE)) ?
                       COUNT_WIDTH'(TRAINING_DATA_SIZE) : num_instr_i;
  assign active      = (state_q == FETCH) || (state_q == CAPTURE) ||
                       (state_q == PREDICT) || (state_q == UPDATE);
  assign mispredict  = taken_q ^ pred_taken_q;
  assign branch_next = branch_count_o + COUNT_WIDTH'(1);

  always_comb begin
    state_d       = state_q;
    index_d       = index_q;
    len_d         = len_q;
    pc_d          = pc_q;
    taken_d       = taken_q;
    pred_taken_d  = pred_taken_q;
    cnt_clear     = 1'b0;
    br_inc        = 1'b0;
    mp_inc        = 1'b0;
    trace_rd_en_o = 1'b0;
    pred_req_o    = 1'b0;
    upd_req_o     = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start_i && !abort_i) begin
          len_d     = len_clamped;
          index_d   = '0;
          cnt_clear = 1'b1;
          state_d   = (len_clamped == '0) ? DONE : FETCH;
        end
      end
      FETCH: begin
        trace_rd_en_o = 1'b1;
        state_d       = CAPTURE;
      end
      CAPTURE: begin
        pc_d    = trace_pc_i;
        taken_d = trace_taken_i;
        state_d = PREDICT;
      end
      PREDICT: begin
        pred_req_o = 1'b1;
        if (pred_valid_i) begin
          pred_taken_d = pred_taken_i;
          state_d      = UPDATE;
        end
      end
      UPDATE: begin
        upd_req_o = 1'b1;
        if (upd_ack_i) begin
          br_inc = 1'b1;
          mp_inc = mispredict;
          // The index only advances when another record follows, so it never wraps.
          if (branch_next == len_q) begin
            state_d = DONE;
          end else begin
            index_d = index_q + INSTRUCTION_INDEX_SIZE'(1);
            state_d = FETCH;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Abort outranks a same-cycle ack: the branch in flight is not counted.
    if (abort_i && active) begin
      state_d = IDLE;
      index_d = index_q;
      br_inc  = 1'b0;
      mp_inc  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      index_q      <= '0;
      len_q        <= '0;
      pc_q         <= '0;
      taken_q      <= 1'b0;
      pred_taken_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      index_q      <= index_d;
      len_q        <= len_d;
      pc_q         <= pc_d;
      taken_q      <= taken_d;
      pred_taken_q <= pred_taken_d;
    end
  end

  sat_event_counter #(.COUNT_WIDTH(COUNT_WIDTH)) u_branch_cnt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (cnt_clear),
    .inc_i   (br_inc),
    .count_o (branch_count_o)
  );

  sat_event_counter #(.COUNT_WIDTH(COUNT_WIDTH)) u_mispredict_cnt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (cnt_clear),
    .inc_i   (mp_inc),
    .count_o (mispredict_count_o)
  );

  assign trace_addr_o     = index_q;
  assign pred_pc_o        = pc_q;
  assign upd_pc_o         = pc_q;
  assign upd_taken_o      = taken_q;
  assign upd_mispredict_o = mispredict;
  assign busy_o           = active;
  assign done_o           = (state_q == DONE);

endmodule

// File: tb/tb_tage_trace_sequencer.sv
// tb/tb_tage_trace_sequencer.sv - randomized self-checking bench for tage_trace_sequencer
module tb_tage_trace_sequencer;
  localparam int TDS = 256;
  localparam int IW  = 8;
  localparam int PCW = 32;
  localparam int CW  = 9;

  logic           clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic [CW-1:0]  num_instr = '0;
  logic           trace_rd_en;
  logic [IW-1:0]  trace_addr;
  logic [PCW-1:0] trace_pc = '0;
  logic           trace_taken = 1'b0;
  logic           pred_req;
  logic [PCW-1:0] pred_pc;
  logic           pred_valid = 1'b0, pred_taken = 1'b0;
  logic           upd_req;
  logic [PCW-1:0] upd_pc;
  logic           upd_taken, upd_mispredict;
  logic           upd_ack = 1'b0;
  logic           busy, done;
  logic [CW-1:0]  branch_count, mispredict_count;

  int n_cmp = 0, n_bad = 0;

  logic [PCW-1:0] mem_pc[TDS];
  logic           mem_taken[TDS];

  int pdelay = 0, udelay = 0, pmode = 0, noise = 0, pwait = 0, uwait = 0;
  int stab_err = 0, req_cycles = 0;
  int             rd_q[$];
  bit             pred_q[$];
  logic [PCW-1:0] rec_pc[$];
  bit             rec_taken[$];
  bit             rec_mis[$];
  logic           prev_preq = 1'b0, prev_ureq = 1'b0, prev_ut = 1'b0, prev_um = 1'b0;
  logic [PCW-1:0] prev_ppc = '0, prev_upc = '0;

  tage_trace_sequencer dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .start_i            (start),
    .abort_i            (abort),
    .num_instr_i        (num_instr),
    .trace_rd_en_o      (trace_rd_en),
    .trace_addr_o       (trace_addr),
    .trace_pc_i         (trace_pc),
    .trace_taken_i      (trace_taken),
    .pred_req_o         (pred_req),
    .pred_pc_o          (pred_pc),
    .pred_valid_i       (pred_valid),
    .pred_taken_i       (pred_taken),
    .upd_req_o          (upd_req),
    .upd_pc_o           (upd_pc),
    .upd_taken_o        (upd_taken),
    .upd_mispredict_o   (upd_mispredict),
    .upd_ack_i          (upd_ack),
    .busy_o             (busy),
    .done_o             (done),
    .branch_count_o     (branch_count),
    .mispredict_count_o (mispredict_count)
  );

  always #5 clk = ~clk;

  // Synchronous trace ROM: data valid exactly one cycle after the read strobe, junk otherwise.
  always @(posedge clk) begin
    if (trace_rd_en) begin
      trace_pc    <= mem_pc[trace_addr];
      trace_taken <= mem_taken[trace_addr];
    end else begin
      trace_pc    <= $urandom;
      trace_taken <= 1'($urandom);
    end
  end

  // Monitor plus predictor/update responders, all acting on the falling edge.
  always @(negedge clk) begin
    if (trace_rd_en) rd_q.push_back(int'(trace_addr));
    if (pred_req || upd_req) req_cycles++;
    if (pred_req && prev_preq && pred_pc !== prev_ppc) stab_err++;
    if (upd_req && prev_ureq && {upd_pc, upd_taken, upd_mispredict} !== {prev_upc, prev_ut, prev_um})
      stab_err++;
    prev_preq = pred_req;
    prev_ppc  = pred_pc;
    prev_ureq = upd_req;
    prev_upc  = upd_pc;
    prev_ut   = upd_taken;
    prev_um   = upd_mispredict;
    if (pred_req) begin
      if (pwait >= pdelay) begin
        pred_valid = 1'b1;
        pred_taken = (pmode != 0) ? 1'($urandom) : 1'b1;
        pred_q.push_back(pred_taken);
        pwait = 0;
      end else begin
        pred_valid = 1'b0;
        pwait++;
      end
    end else begin
      pwait      = 0;
      pred_valid = (noise != 0) ? 1'($urandom) : 1'b0;
      pred_taken = 1'($urandom);
    end
    if (upd_req) begin
      if (uwait >= udelay) begin
        upd_ack = 1'b1;
        rec_pc.push_back(upd_pc);
        rec_taken.push_back(upd_taken);
        rec_mis.push_back(upd_mispredict);
        uwait = 0;
      end else begin
        upd_ack = 1'b0;
        uwait++;
      end
    end else begin
      uwait   = 0;
      upd_ack = 1'b0;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  function automatic int model_mis(int len);
    int m = 0;
    for (int i = 0; i < len && i < pred_q.size(); i++)
      if (pred_q[i] != mem_taken[i]) m++;
    return m;
  endfunction

  function automatic int bad_records(int len);
    int bad = 0;
    if (rec_pc.size() != len || pred_q.size() < len) return -1;
    for (int i = 0; i < len; i++)
      if (rec_pc[i] !== mem_pc[i] || rec_taken[i] !== mem_taken[i] ||
          rec_mis[i] !== (pred_q[i] != mem_taken[i])) bad++;
    return bad;
  endfunction

  function automatic bit seq_ok(int len);
    if (rd_q.size() != len) return 0;
    for (int i = 0; i < len; i++)
      if (rd_q[i] != i) return 0;
    return 1;
  endfunction

  function automatic logic [PCW*2+CW*2+IW+7-1:0] all_outs();
    return {trace_rd_en, trace_addr, pred_req, pred_pc, upd_req, upd_pc, upd_taken,
            upd_mispredict, busy, done, branch_count, mispredict_count};
  endfunction

  task automatic clear_logs();
    rd_q.delete(); pred_q.delete(); rec_pc.delete(); rec_taken.delete(); rec_mis.delete();
    stab_err = 0; req_cycles = 0;
  endtask

  task automatic randomize_mem();
    for (int i = 0; i < TDS; i++) begin
      mem_pc[i]    = $urandom;
      mem_taken[i] = 1'($urandom);
    end
  endtask

  task automatic run(input int n, input int bound, output int cycles);
    @(negedge clk);
    num_instr = CW'(n);
    start     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start  = 1'b0;
    cycles = 0;
    while (!done && cycles < bound) begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    int seen;
    #12;
    n_cmp++;
    if (all_outs() !== '0) begin
      n_bad++; $display("FAIL reset_outputs: got %h expected 0", all_outs());
    end
    @(negedge clk); rst_n = 1'b1;
    randomize_mem(); clear_logs();
    pdelay = 6;
    @(negedge clk); num_instr = CW'(3); start = 1'b1;
    @(negedge clk); start = 1'b0;
    seen = 0;
    for (int i = 0; i < 20 && !pred_req; i++) @(negedge clk);
    seen = pred_req ? 1 : 0;
    n_cmp++;
    if (seen != 1) begin
      n_bad++; $display("FAIL reset_reach_predict: got pred_req=%0d expected 1", seen);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (all_outs() !== '0) begin
      n_bad++; $display("FAIL reset_async_mid_predict: got %h expected 0", all_outs());
    end
    @(negedge clk); rst_n = 1'b1; pdelay = 0;
    clear_logs();
    repeat (4) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || rd_q.size() != 0 || req_cycles != 0) begin
      n_bad++; $display("FAIL reset_idle_after_release: got busy=%b done=%b reads=%0d reqs=%0d expected 0/0/0/0",
                        busy, done, rd_q.size(), req_cycles);
    end
  endtask

  task automatic test_basic();
    int cycles;
    randomize_mem();
    mem_taken[0] = 1; mem_taken[1] = 1; mem_taken[2] = 0; mem_taken[3] = 1;
    pmode = 0; noise = 0; pdelay = 0; udelay = 0;
    clear_logs();
    run(4, 100, cycles);
    n_cmp++;
    if (cycles != 16) begin n_bad++; $display("FAIL basic_cycles: got %0d expected 16", cycles); end
    n_cmp++;
    if (!seq_ok(4)) begin n_bad++; $display("FAIL basic_addrs: got %0d reads expected 0..3 once each", rd_q.size()); end
    n_cmp++;
    if (branch_count !== 4) begin n_bad++; $display("FAIL basic_branches: got %0d expected 4", branch_count); end
    n_cmp++;
    if (mispredict_count !== 1) begin n_bad++; $display("FAIL basic_mispredicts: got %0d expected 1", mispredict_count); end
    n_cmp++;
    if (bad_records(4) != 0) begin n_bad++; $display("FAIL basic_records: got %0d bad expected 0", bad_records(4)); end
    repeat (5) @(negedge clk);
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0 || branch_count !== 4) begin
      n_bad++; $display("FAIL basic_done_held: got done=%b busy=%b bc=%0d expected 1/0/4", done, busy, branch_count);
    end
  endtask

  task automatic test_zero();
    int cycles;
    clear_logs();
    run(0, 10, cycles);
    n_cmp++;
    if (cycles != 0 || done !== 1'b1) begin
      n_bad++; $display("FAIL zero_done: got cycles=%0d done=%b expected 0/1", cycles, done);
    end
    repeat (5) @(negedge clk);
    n_cmp++;
    if (rd_q.size() != 0 || req_cycles != 0 || branch_count !== 0 || mispredict_count !== 0) begin
      n_bad++; $display("FAIL zero_quiet: got reads=%0d reqs=%0d bc=%0d mc=%0d expected 0/0/0/0",
                        rd_q.size(), req_cycles, branch_count, mispredict_count);
    end
  endtask

  task automatic test_clamp();
    int cycles;
    randomize_mem();
    pmode = 1; noise = 1;
    clear_logs();
    run(300, 1200, cycles);
    n_cmp++;
    if (cycles != 1024 || done !== 1'b1) begin
      n_bad++; $display("FAIL clamp_cycles: got %0d done=%b expected 1024/1", cycles, done);
    end
    n_cmp++;
    if (branch_count !== 256) begin n_bad++; $display("FAIL clamp_branches: got %0d expected 256", branch_count); end
    n_cmp++;
    if (!seq_ok(256) || rd_q[$] != 255) begin
      n_bad++; $display("FAIL clamp_addrs: got %0d reads expected 256 ending at 255", rd_q.size());
    end
    n_cmp++;
    if (mispredict_count !== CW'(model_mis(256))) begin
      n_bad++; $display("FAIL clamp_mispredicts: got %0d expected %0d", mispredict_count, model_mis(256));
    end
    n_cmp++;
    if (bad_records(256) != 0) begin n_bad++; $display("FAIL clamp_records: got %0d bad expected 0", bad_records(256)); end
  endtask

  task automatic test_delays();
    int cycles;
    randomize_mem();
    pmode = 1; noise = 0; pdelay = 3; udelay = 2;
    clear_logs();
    run(6, 200, cycles);
    n_cmp++;
    if (cycles != 54) begin n_bad++; $display("FAIL delay_cycles: got %0d expected 54", cycles); end
    n_cmp++;
    if (stab_err != 0) begin n_bad++; $display("FAIL delay_stability: got %0d changes expected 0", stab_err); end
    n_cmp++;
    if (branch_count !== 6 || mispredict_count !== CW'(model_mis(6))) begin
      n_bad++; $display("FAIL delay_counts: got %0d/%0d expected 6/%0d", branch_count, mispredict_count, model_mis(6));
    end
    n_cmp++;
    if (bad_records(6) != 0) begin n_bad++; $display("FAIL delay_records: got %0d bad expected 0", bad_records(6)); end
    pdelay = 0; udelay = 0;
  endtask

  task automatic test_abort_and_busy_start();
    int guard;
    randomize_mem();
    pmode = 1; noise = 0; pdelay = 0; udelay = 0;
    clear_logs();
    @(negedge clk); num_instr = CW'(5); start = 1'b1;
    @(negedge clk); start = 1'b0;
    guard = 0;
    while (branch_count != 1 && guard < 50) begin @(negedge clk); guard++; end
    num_instr = CW'(1); start = 1'b1;
    @(negedge clk); start = 1'b0; num_instr = CW'(5);
    guard = 0;
    while (!(upd_req && branch_count == 2) && guard < 50) begin @(negedge clk); guard++; end
    n_cmp++;
    if (guard >= 50) begin n_bad++; $display("FAIL abort_reach_branch2: got timeout expected upd_req on branch 2"); end
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || pred_req !== 1'b0 || upd_req !== 1'b0) begin
      n_bad++; $display("FAIL abort_idle: got busy=%b done=%b preq=%b ureq=%b expected 0/0/0/0",
                        busy, done, pred_req, upd_req);
    end
    n_cmp++;
    if (branch_count !== 2 || mispredict_count !== CW'(model_mis(2))) begin
      n_bad++; $display("FAIL abort_counts: got %0d/%0d expected 2/%0d", branch_count, mispredict_count, model_mis(2));
    end
    n_cmp++;
    if (!seq_ok(3)) begin n_bad++; $display("FAIL abort_busy_start_addrs: got %0d reads expected 0,1,2", rd_q.size()); end
    start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || rd_q.size() != 3 || branch_count !== 2) begin
      n_bad++; $display("FAIL start_abort_idle: got busy=%b reads=%0d bc=%0d expected 0/3/2", busy, rd_q.size(), branch_count);
    end
  endtask

  task automatic test_random();
    int cycles, n, exp_cycles;
    for (int r = 0; r < 6; r++) begin
      randomize_mem();
      n = $urandom_range(1, 24);
      pdelay = $urandom_range(0, 3);
      udelay = $urandom_range(0, 3);
      pmode = 1; noise = 1;
      exp_cycles = n * (4 + pdelay + udelay);
      clear_logs();
      run(n, exp_cycles + 20, cycles);
      n_cmp++;
      if (cycles != exp_cycles || done !== 1'b1) begin
        n_bad++; $display("FAIL rand%0d_cycles: got %0d done=%b expected %0d/1", r, cycles, done, exp_cycles);
      end
      n_cmp++;
      if (branch_count !== CW'(n) || mispredict_count !== CW'(model_mis(n))) begin
        n_bad++; $display("FAIL rand%0d_counts: got %0d/%0d expected %0d/%0d", r, branch_count, mispredict_count, n, model_mis(n));
      end
      n_cmp++;
      if (!seq_ok(n) || bad_records(n) != 0 || stab_err != 0) begin
        n_bad++; $display("FAIL rand%0d_trace: got reads=%0d badrec=%0d stab=%0d expected %0d/0/0",
                          r, rd_q.size(), bad_records(n), stab_err, n);
      end
    end
    pdelay = 0; udelay = 0; noise = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_clamp();
    test_delays();
    test_abort_and_busy_start();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
